// File: rtl/aq_axi_lite_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aq_axi_lite_pkg
//  Description : Shared AXI4-Lite response codes, attribute defaults and the
//                state encoding of the aq_axi_lite_master initiator.
//  Revision    : 1.0 - initial release
// ============================================================================
package aq_axi_lite_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam logic [3:0] AXCACHE_DEFAULT = 4'b0011;
    localparam logic [2:0] AXPROT_DEFAULT  = 3'b000;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_WR   = 3'd1;
    localparam state_t S_WB   = 3'd2;
    localparam state_t S_RA   = 3'd3;
    localparam state_t S_RD   = 3'd4;
    localparam state_t S_RSP  = 3'd5;

endpackage
`default_nettype wire

// File: rtl/aq_axi_lite_wdog.sv
`default_nettype none
// ============================================================================
//  Module      : aq_axi_lite_wdog
//  Description : Saturating stall counter with a sticky timeout flag for the
//                AXI4-Lite initiator. A limit of 0 disables it.
//  Revision    : 1.0 - initial release
// ============================================================================
module aq_axi_lite_wdog #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_busy,
    input  logic i_clear,
    input  logic i_accept,
    output logic o_timeout
);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wdog_on
            localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(TIMEOUT_CYCLES);

            logic [c_cnt_w-1:0] r_cnt;
            logic [c_cnt_w-1:0] w_cnt_next;
            logic               r_flag;

            // Clear wins over increment; the count parks at the limit.
            always_comb begin
                w_cnt_next = r_cnt;
                if (i_clear) begin
                    w_cnt_next = '0;
                end else if (i_busy && (r_cnt != c_limit)) begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt  <= '0;
                    r_flag <= 1'b0;
                end else begin
                    r_cnt <= w_cnt_next;
                    if (i_accept) begin
                        r_flag <= 1'b0;
                    end else if (w_cnt_next == c_limit) begin
                        r_flag <= 1'b1;
                    end
                end
            end

            assign o_timeout = r_flag;
        end else begin : g_wdog_off
            logic w_unused;
            assign w_unused  = &{1'b0, clk, rst, i_busy, i_clear, i_accept};
            assign o_timeout = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/aq_axi_lite_master.sv
`default_nettype none
// ============================================================================
//  Module      : aq_axi_lite_master
//  Description : Single-outstanding AXI4-Lite initiator driven by a local
//                command/response interface; all outputs registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module aq_axi_lite_master
    import aq_axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  ACLK,
    input  logic                  RST,

    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic                  CMD_WRITE,
    input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [31:0]           CMD_WDATA,
    input  logic [3:0]            CMD_WSTRB,

    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [31:0]           RSP_RDATA,
    output logic [1:0]            RSP_RESP,
    output logic                  RSP_WRITE,
    output logic                  TIMEOUT,

    output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [3:0]            M_AXI_AWCACHE,
    output logic [2:0]            M_AXI_AWPROT,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,

    output logic [31:0]           M_AXI_WDATA,
    output logic [3:0]            M_AXI_WSTRB,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,

    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY,
    input  logic [1:0]            M_AXI_BRESP,

    output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [3:0]            M_AXI_ARCACHE,
    output logic [2:0]            M_AXI_ARPROT,
    output logic                  M_AXI_ARVALID,
    input  logic                  M_AXI_ARREADY,

    input  logic [31:0]           M_AXI_RDATA,
    input  logic [1:0]            M_AXI_RRESP,
    input  logic                  M_AXI_RVALID,
    output logic                  M_AXI_RREADY
);

    state_t                r_state;
    logic                  r_cmd_ready;
    logic                  r_rsp_valid;
    logic [31:0]           r_rsp_rdata;
    logic [1:0]            r_rsp_resp;
    logic                  r_rsp_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wstrb;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_bready;
    logic                  r_arvalid;
    logic                  r_rready;

    logic w_accept;
    logic w_aw_done;
    logic w_w_done;
    logic w_handshake;
    logic w_busy;

    assign w_accept  = (r_state == S_IDLE) && CMD_VALID && r_cmd_ready;

    // A write channel counts as done once it has handshaken or does so now.
    assign w_aw_done = !r_awvalid || M_AXI_AWREADY;
    assign w_w_done  = !r_wvalid  || M_AXI_WREADY;

    assign w_handshake = (r_awvalid && M_AXI_AWREADY) || (r_wvalid  && M_AXI_WREADY) ||
                         (r_bready  && M_AXI_BVALID)  || (r_arvalid && M_AXI_ARREADY) ||
                         (r_rready  && M_AXI_RVALID);

    assign w_busy = (r_state == S_WR) || (r_state == S_WB) ||
                    (r_state == S_RA) || (r_state == S_RD);

    always_ff @(posedge ACLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= OKAY;
            r_rsp_write <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr      <= CMD_ADDR;
                        r_wdata     <= CMD_WDATA;
                        r_wstrb     <= CMD_WSTRB;
                        r_cmd_ready <= 1'b0;
                        if (CMD_WRITE) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_WR;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= S_RA;
                        end
                    end
                end
                S_WR: begin
                    if (r_awvalid && M_AXI_AWREADY) begin
                        r_awvalid <= 1'b0;
                    end
                    if (r_wvalid && M_AXI_WREADY) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= S_WB;
                    end
                end
                S_WB: begin
                    if (M_AXI_BVALID) begin
                        r_bready    <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_rsp_resp  <= M_AXI_BRESP;
                        r_rsp_write <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RSP;
                    end
                end
                S_RA: begin
                    if (M_AXI_ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RD;
                    end
                end
                S_RD: begin
                    if (M_AXI_RVALID) begin
                        r_rready    <= 1'b0;
                        r_rsp_rdata <= M_AXI_RDATA;
                        r_rsp_resp  <= M_AXI_RRESP;
                        r_rsp_write <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (RSP_READY) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    aq_axi_lite_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk       (ACLK),
        .rst       (RST),
        .i_busy    (w_busy),
        .i_clear   (w_handshake || w_accept),
        .i_accept  (w_accept),
        .o_timeout (TIMEOUT)
    );

    assign CMD_READY     = r_cmd_ready;
    assign RSP_VALID     = r_rsp_valid;
    assign RSP_RDATA     = r_rsp_rdata;
    assign RSP_RESP      = r_rsp_resp;
    assign RSP_WRITE     = r_rsp_write;

    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWCACHE = AXCACHE_DEFAULT;
    assign M_AXI_AWPROT  = AXPROT_DEFAULT;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARCACHE = AXCACHE_DEFAULT;
    assign M_AXI_ARPROT  = AXPROT_DEFAULT;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;

endmodule
`default_nettype wire

// File: tb/tb_aq_axi_lite_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aq_axi_lite_master
//  Description : Self-checking bench for aq_axi_lite_master with a reactive
//                AXI4-Lite slave and a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aq_axi_lite_master;

    localparam int AW = 16;
    localparam int TO = 16;

    logic          ACLK = 1'b0;
    logic          RST  = 1'b1;
    logic          CMD_VALID = 1'b0, CMD_READY, CMD_WRITE = 1'b0;
    logic [AW-1:0] CMD_ADDR = '0;
    logic [31:0]   CMD_WDATA = '0;
    logic [3:0]    CMD_WSTRB = '0;
    logic          RSP_VALID, RSP_READY = 1'b0, RSP_WRITE, TIMEOUT;
    logic [31:0]   RSP_RDATA;
    logic [1:0]    RSP_RESP;
    logic [AW-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
    logic [3:0]    M_AXI_AWCACHE, M_AXI_ARCACHE, M_AXI_WSTRB;
    logic [2:0]    M_AXI_AWPROT, M_AXI_ARPROT;
    logic          M_AXI_AWVALID, M_AXI_AWREADY = 1'b0;
    logic [31:0]   M_AXI_WDATA;
    logic          M_AXI_WVALID, M_AXI_WREADY = 1'b0;
    logic          M_AXI_BVALID = 1'b0, M_AXI_BREADY;
    logic [1:0]    M_AXI_BRESP = '0;
    logic          M_AXI_ARVALID, M_AXI_ARREADY = 1'b0;
    logic [31:0]   M_AXI_RDATA = '0;
    logic [1:0]    M_AXI_RRESP = '0;
    logic          M_AXI_RVALID = 1'b0, M_AXI_RREADY;

    always #5 ACLK = ~ACLK;

    aq_axi_lite_master #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .ACLK(ACLK), .RST(RST),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_WRITE(CMD_WRITE),
        .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_WSTRB(CMD_WSTRB),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA),
        .RSP_RESP(RSP_RESP), .RSP_WRITE(RSP_WRITE), .TIMEOUT(TIMEOUT),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_BRESP(M_AXI_BRESP),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARCACHE(M_AXI_ARCACHE), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    wstrb;
        int            aw_dly, w_dly, b_dly, ar_dly, r_dly, rsp_dly;
        logic [31:0]   sl_rdata;
        logic [1:0]    sl_resp;
        logic [31:0]   exp_rdata;
        logic [1:0]    exp_resp;
        int            exp_lat;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    int   wd;
    logic exp_to;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    function automatic vec_t mk(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wstrb, input int aw, input int w, input int b,
                                input int ar, input int r, input int rsp, input logic [31:0] sl_rdata,
                                input logic [1:0] sl_resp, input logic [31:0] exp_rdata,
                                input logic [1:0] exp_resp, input int exp_lat);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
        v.aw_dly = aw; v.w_dly = w; v.b_dly = b; v.ar_dly = ar; v.r_dly = r; v.rsp_dly = rsp;
        v.sl_rdata = sl_rdata; v.sl_resp = sl_resp;
        v.exp_rdata = exp_rdata; v.exp_resp = exp_resp; v.exp_lat = exp_lat;
        return v;
    endfunction

    // Transaction-level expectation: response echoes the slave, latency is
    // three cycles plus the slowest address/data phase plus the response wait.
    function automatic vec_t model(input vec_t v);
        vec_t m = v;
        m.exp_rdata = v.wr ? 32'h0 : v.sl_rdata;
        m.exp_resp  = v.sl_resp;
        m.exp_lat   = v.wr ? 3 + ((v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly) + v.b_dly
                           : 3 + v.ar_dly + v.r_dly;
        return m;
    endfunction

    task automatic check_idle_after_reset(input string tag);
        chk({tag, "_cmd_ready"}, CMD_READY, 1);
        chk({tag, "_rsp_valid"}, RSP_VALID, 0);
        chk({tag, "_valids"}, {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}, 0);
        chk({tag, "_readies"}, {M_AXI_BREADY, M_AXI_RREADY}, 0);
        chk({tag, "_rsp_rdata"}, RSP_RDATA, 0);
        chk({tag, "_rsp_resp_write"}, {RSP_RESP, RSP_WRITE}, 0);
        chk({tag, "_timeout"}, TIMEOUT, 0);
        chk({tag, "_addr"}, M_AXI_AWADDR, 0);
        chk({tag, "_wdata_wstrb"}, {M_AXI_WDATA[27:0], M_AXI_WSTRB}, 0);
        chk({tag, "_cache_prot"}, {M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_ARCACHE, M_AXI_ARPROT},
            {4'b0011, 3'b000, 4'b0011, 3'b000});
    endtask

    task automatic do_txn(input vec_t v);
        int   cyc, bud;
        int   aw_n, w_n, b_n, ar_n, r_n, aw_seen, w_seen, ar_seen, b_wait, r_wait;
        logic p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr;
        logic [31:0] h_rdata;
        logic [2:0]  h_rw;
        aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
        aw_seen = 0; w_seen = 0; ar_seen = 0; b_wait = 0; r_wait = 0;
        {p_awv, p_awr, p_wv, p_wr, p_bv, p_br, p_arv, p_arr, p_rv, p_rr} = '0;

        bud = 0;
        while (!CMD_READY && bud < 50) begin tick(); bud++; end
        chk("cmd_ready_idle", CMD_READY, 1);
        CMD_VALID = 1'b1; CMD_WRITE = v.wr; CMD_ADDR = v.addr;
        CMD_WDATA = v.wdata; CMD_WSTRB = v.wstrb;
        tick();
        CMD_VALID = 1'b0; CMD_WDATA = $urandom(); CMD_ADDR = AW'($urandom());
        chk("cmd_ready_busy", CMD_READY, 0);
        cyc = 1; wd = 0; exp_to = 1'b0;

        forever begin
            if (p_awv && p_awr) aw_n++;
            if (p_wv  && p_wr ) w_n++;
            if (p_bv  && p_br ) b_n++;
            if (p_arv && p_arr) ar_n++;
            if (p_rv  && p_rr ) r_n++;
            if (cyc > 1) begin
                if ((p_awv && p_awr) || (p_wv && p_wr) || (p_bv && p_br) ||
                    (p_arv && p_arr) || (p_rv && p_rr)) wd = 0;
                else wd++;
                if (wd >= TO) exp_to = 1'b1;
            end
            chk("timeout_flag", TIMEOUT, exp_to);
            if (RSP_VALID || cyc >= 200) break;

            if (p_awv && !p_awr) chk("awvalid_held", M_AXI_AWVALID, 1);
            if (p_wv  && !p_wr ) chk("wvalid_held",  M_AXI_WVALID, 1);
            if (p_arv && !p_arr) chk("arvalid_held", M_AXI_ARVALID, 1);
            if (p_br  && !p_bv ) chk("bready_held",  M_AXI_BREADY, 1);
            if (p_rr  && !p_rv ) chk("rready_held",  M_AXI_RREADY, 1);
            if (p_awv && p_awr) chk("awvalid_drop", M_AXI_AWVALID, 0);
            if (p_wv  && p_wr ) chk("wvalid_drop",  M_AXI_WVALID, 0);
            if (p_arv && p_arr) chk("arvalid_drop", M_AXI_ARVALID, 0);
            if (M_AXI_AWVALID) chk("awaddr", M_AXI_AWADDR, v.addr);
            if (M_AXI_WVALID)  chk("wdata_wstrb", {M_AXI_WDATA[27:0], M_AXI_WSTRB},
                                   {v.wdata[27:0], v.wstrb});
            if (M_AXI_WVALID)  chk("wdata_hi", M_AXI_WDATA, v.wdata);
            if (M_AXI_ARVALID) chk("araddr", M_AXI_ARADDR, v.addr);
            if (v.wr) chk("no_read_chan", {M_AXI_ARVALID, M_AXI_RREADY}, 0);
            else      chk("no_write_chan", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 0);

            M_AXI_AWREADY = M_AXI_AWVALID && (aw_seen >= v.aw_dly);
            if (M_AXI_AWVALID) aw_seen++;
            M_AXI_WREADY = M_AXI_WVALID && (w_seen >= v.w_dly);
            if (M_AXI_WVALID) w_seen++;
            M_AXI_ARREADY = M_AXI_ARVALID && (ar_seen >= v.ar_dly);
            if (M_AXI_ARVALID) ar_seen++;
            if (aw_n > 0 && w_n > 0 && b_n == 0) begin
                M_AXI_BVALID = (b_wait >= v.b_dly); b_wait++;
            end else M_AXI_BVALID = 1'b0;
            M_AXI_BRESP = v.sl_resp;
            if (ar_n > 0 && r_n == 0) begin
                M_AXI_RVALID = (r_wait >= v.r_dly); r_wait++;
            end else M_AXI_RVALID = 1'b0;
            M_AXI_RDATA = M_AXI_RVALID ? v.sl_rdata : $urandom();
            M_AXI_RRESP = v.sl_resp;

            p_awv = M_AXI_AWVALID; p_awr = M_AXI_AWREADY;
            p_wv  = M_AXI_WVALID;  p_wr  = M_AXI_WREADY;
            p_bv  = M_AXI_BVALID;  p_br  = M_AXI_BREADY;
            p_arv = M_AXI_ARVALID; p_arr = M_AXI_ARREADY;
            p_rv  = M_AXI_RVALID;  p_rr  = M_AXI_RREADY;
            tick();
            cyc++;
        end
        {M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BVALID, M_AXI_ARREADY, M_AXI_RVALID} = '0;

        chk("rsp_valid", RSP_VALID, 1);
        chk("latency", cyc, v.exp_lat);
        chk("rsp_rdata", RSP_RDATA, v.exp_rdata);
        chk("rsp_resp", RSP_RESP, v.exp_resp);
        chk("rsp_write", RSP_WRITE, v.wr);
        chk("hs_counts", {aw_n[3:0], w_n[3:0], b_n[3:0], ar_n[3:0], r_n[3:0]},
            v.wr ? 20'h11100 : 20'h00011);

        h_rdata = RSP_RDATA; h_rw = {RSP_RESP, RSP_WRITE};
        CMD_VALID = (v.rsp_dly > 0); CMD_WRITE = ~v.wr;
        for (int k = 0; k < v.rsp_dly; k++) begin
            tick();
            chk("hold_rsp_valid", RSP_VALID, 1);
            chk("hold_rsp_fields", {RSP_RDATA[28:0], RSP_RESP, RSP_WRITE}, {h_rdata[28:0], h_rw});
            chk("hold_cmd_ready", CMD_READY, 0);
            chk("hold_timeout", TIMEOUT, exp_to);
        end
        RSP_READY = 1'b1;
        tick();
        RSP_READY = 1'b0; CMD_VALID = 1'b0;
        chk("rsp_valid_cleared", RSP_VALID, 0);
        chk("cmd_ready_restored", CMD_READY, 1);
    endtask

    vec_t tbl[7];
    vec_t rv;

    initial begin
        tbl[0] = mk(1, 'h0010, 'hDEADBEEF, 'hF, 0, 0, 0, 0, 0,  0, 'h0,        2'd0, 'h0,        2'd0, 3);
        tbl[1] = mk(1, 'h0024, 'hA5A50F0F, 'h3, 3, 0, 0, 0, 0,  1, 'h0,        2'd0, 'h0,        2'd0, 6);
        tbl[2] = mk(0, 'h0100, 'h0,        'h0, 0, 0, 0, 0, 5,  0, 'h12345678, 2'd2, 'h12345678, 2'd2, 8);
        tbl[3] = mk(1, 'h0003, 'h01020304, 'h1, 0, 2, 1, 0, 0,  0, 'h0,        2'd3, 'h0,        2'd3, 6);
        tbl[4] = mk(0, 'hFFFC, 'h0,        'h0, 0, 0, 0, 2, 0, 10, 'hCAFEF00D, 2'd0, 'hCAFEF00D, 2'd0, 5);
        tbl[5] = mk(0, 'h0200, 'h0,        'h0, 0, 0, 0, 20, 0, 2, 'h0BADC0DE, 2'd1, 'h0BADC0DE, 2'd1, 23);
        tbl[6] = mk(1, 'h0208, 'h55AA55AA, 'h8, 1, 1, 0, 0, 0,  0, 'h0,        2'd2, 'h0,        2'd2, 4);

        repeat (3) tick();
        RST = 1'b0;
        check_idle_after_reset("reset");

        for (int i = 0; i < 7; i++) do_txn(tbl[i]);

        // Reset while waiting for B: transaction vanishes without a response.
        CMD_VALID = 1'b1; CMD_WRITE = 1'b1; CMD_ADDR = 'h0040;
        CMD_WDATA = 'h11112222; CMD_WSTRB = 'hF;
        tick();
        CMD_VALID = 1'b0; M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1;
        tick();
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
        chk("wb_bready", M_AXI_BREADY, 1);
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_idle_after_reset("midrst");
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("midrst_no_rsp", RSP_VALID, 0);
        end
        do_txn(tbl[2]);

        for (int i = 0; i < 20; i++) begin
            rv.wr       = 1'($urandom_range(0, 1));
            rv.addr     = AW'($urandom());
            rv.wdata    = $urandom();
            rv.wstrb    = 4'($urandom());
            rv.aw_dly   = $urandom_range(0, 4);
            rv.w_dly    = $urandom_range(0, 4);
            rv.b_dly    = $urandom_range(0, 4);
            rv.ar_dly   = $urandom_range(0, 4);
            rv.r_dly    = $urandom_range(0, 4);
            rv.rsp_dly  = $urandom_range(0, 3);
            rv.sl_rdata = $urandom();
            rv.sl_resp  = 2'($urandom());
            do_txn(model(rv));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
